// File: rtl/alu_mul_sequencer.sv
// Valid/ready sequencer that runs AND/OR/ADD/SUB in one ALU pass and an unsigned
// 32x32->64 multiply as 32 shift-add iterations through the same ALU adder.

module alu1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_operation,
    input  logic             i_bivert,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout
);
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;

    assign w_b   = i_bivert ? ~i_b : i_b;
    assign w_sum = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_cin};

    always_comb begin
        o_result = '0;
        o_cout   = 1'b0;
        case (i_operation)
            2'b00: o_result = i_a & w_b;
            2'b01: o_result = i_a | w_b;
            2'b10: begin
                o_result = w_sum[WIDTH-1:0];
                o_cout   = w_sum[WIDTH];
            end
            default: o_result = '0;
        endcase
    end
endmodule

module alu_mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] rsp_hi,
    output logic             rsp_cout,
    output logic             rsp_err,
    output logic             busy
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic [WIDTH-1:0] r_rsp_hi;
    logic             r_rsp_cout;
    logic             r_rsp_err;

    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;
    logic [1:0]       w_alu_op;
    logic             w_alu_bivert;
    logic             w_alu_cin;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_cout;
    logic [WIDTH-1:0] w_step_s;
    logic             w_step_c;
    logic [WIDTH-1:0] w_next_hi;
    logic [WIDTH-1:0] w_next_lo;

    // In MUL the ALU adds the multiplicand (held in r_a) onto the running high word.
    always_comb begin
        w_alu_a      = r_a;
        w_alu_b      = r_b;
        w_alu_op     = 2'b10;
        w_alu_bivert = 1'b0;
        w_alu_cin    = 1'b0;
        if (r_state == S_MUL) begin
            w_alu_a = r_acc_hi;
            w_alu_b = r_a;
        end else begin
            case (r_op)
                3'b000:  w_alu_op = 2'b00;
                3'b001:  w_alu_op = 2'b01;
                3'b011: begin
                    w_alu_bivert = 1'b1;
                    w_alu_cin    = 1'b1;
                end
                default: w_alu_op = 2'b10;
            endcase
        end
    end

    alu1 #(.WIDTH(WIDTH)) u_alu1 (
        .i_a         (w_alu_a),
        .i_b         (w_alu_b),
        .i_operation (w_alu_op),
        .i_bivert    (w_alu_bivert),
        .i_cin       (w_alu_cin),
        .o_result    (w_alu_result),
        .o_cout      (w_alu_cout)
    );

    assign w_step_s  = r_lo[0] ? w_alu_result : r_acc_hi;
    assign w_step_c  = r_lo[0] & w_alu_cout;
    assign w_next_hi = {w_step_c, w_step_s[WIDTH-1:1]};
    assign w_next_lo = {w_step_s[0], r_lo[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc_hi     <= '0;
            r_lo         <= '0;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_hi     <= '0;
            r_rsp_cout   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op     <= req_op;
                        r_a      <= req_a;
                        r_b      <= req_b;
                        r_acc_hi <= '0;
                        r_lo     <= req_b;
                        r_cnt    <= '0;
                        if (req_op <= 3'b011) begin
                            r_state <= S_EXEC;
                        end else if (req_op == 3'b100) begin
                            r_state <= S_MUL;
                        end else begin
                            r_rsp_result <= '0;
                            r_rsp_hi     <= '0;
                            r_rsp_cout   <= 1'b0;
                            r_rsp_err    <= 1'b1;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_EXEC: begin
                    r_rsp_result <= w_alu_result;
                    r_rsp_cout   <= r_op[1] & w_alu_cout;
                    r_rsp_hi     <= '0;
                    r_rsp_err    <= 1'b0;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_MUL: begin
                    r_acc_hi <= w_next_hi;
                    r_lo     <= w_next_lo;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_rsp_hi     <= w_next_hi;
                        r_rsp_result <= w_next_lo;
                        r_rsp_cout   <= 1'b0;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_hi     = r_rsp_hi;
    assign rsp_cout   = r_rsp_cout;
    assign rsp_err    = r_rsp_err;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench: the driver queues hand-computed responses at issue time and a
// negedge monitor checks every response, its latency, and stability under backpressure.

module tb_alu_mul_sequencer;
    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [31:0] rsp_hi;
    logic        rsp_cout;
    logic        rsp_err;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        cout;
        logic        err;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    alu_mul_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_hi     (rsp_hi),
        .rsp_cout   (rsp_cout),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares each new response, then checks it holds while stalled.
    initial begin
        exp_t        e;
        exp_t        snap;
        logic        prev_valid;
        prev_valid = 1'b0;
        snap = '{res: 0, hi: 0, cout: 0, err: 0, lat: 0, acc_cyc: 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (rsp_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_response", {63'd0, rsp_valid}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("rsp: result=%08h hi=%08h cout=%0b err=%0b latency=%0d",
                                 rsp_result, rsp_hi, rsp_cout, rsp_err, cyc - e.acc_cyc);
                        chk("rsp_result", {32'd0, rsp_result}, {32'd0, e.res});
                        chk("rsp_hi", {32'd0, rsp_hi}, {32'd0, e.hi});
                        chk("rsp_cout", {63'd0, rsp_cout}, {63'd0, e.cout});
                        chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
                        chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                    end
                    snap.res  = rsp_result;
                    snap.hi   = rsp_hi;
                    snap.cout = rsp_cout;
                    snap.err  = rsp_err;
                end else if (rsp_valid && prev_valid) begin
                    chk("stall_stable", {rsp_result, rsp_hi[29:0], rsp_cout, rsp_err},
                        {snap.res, snap.hi[29:0], snap.cout, snap.err});
                    chk("stall_ready_busy", {62'd0, req_ready, busy}, 64'd1);
                end
                prev_valid = rsp_valid;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eres, input logic [31:0] ehi,
                         input logic ecout, input logic eerr, input int elat);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        exp_q.push_back('{res: eres, hi: ehi, cout: ecout, err: eerr, lat: elat, acc_cyc: cyc});
        $display("req: op=%0d a=%08h b=%08h", op, a, b);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'b001;
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || rsp_valid) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {rsp_result, rsp_hi[28:0], rsp_valid, rsp_cout, rsp_err}, 64'd0);
        chk("reset_busy_ready", {62'd0, busy, req_ready}, 64'd1);
        rst = 1'b0;

        issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 2);
        issue(3'b011, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 2);
        issue(3'b011, 32'd7, 32'd5, 32'h0000_0002, 32'h0, 1'b1, 1'b0, 2);
        issue(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
        issue(3'b100, 32'h0, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 1'b0, 33);
        issue(3'b100, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 1'b0, 1'b0, 33);
        issue(3'b100, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0, 33);
        issue(3'b100, 32'd3, 32'd5, 32'd15, 32'h0, 1'b0, 1'b0, 33);
        drain();

        // Backpressure: stall the response 10 cycles while a competing request waits.
        rsp_ready = 1'b0;
        issue(3'b001, 32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF, 32'h0, 1'b0, 1'b0, 2);
        w = 0;
        while (!rsp_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        req_valid = 1'b1;
        req_op    = 3'b010;
        req_a     = 32'd100;
        req_b     = 32'd200;
        repeat (10) begin
            @(negedge clk);
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        issue(3'b010, 32'd1, 32'd2, 32'd3, 32'h0, 1'b0, 1'b0, 2);

        issue(3'b111, 32'h1234_5678, 32'h1111_1111, 32'h0, 32'h0, 1'b0, 1'b1, 1);
        issue(3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'h0, 1'b0, 1'b0, 2);
        issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b1, 1);
        drain();

        // Abort a multiply midway; its queued response must never appear.
        issue(3'b100, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 32'h2, 1'b0, 1'b0, 33);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        $display("reset asserted mid-multiply at cycle %0d", cyc);
        chk("abort_outputs", {rsp_result, rsp_hi[28:0], rsp_valid, rsp_cout, rsp_err}, 64'd0);
        chk("abort_busy_ready", {62'd0, busy, req_ready}, 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(3'b010, 32'd3, 32'd4, 32'd7, 32'h0, 1'b0, 1'b0, 2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
